// File: rtl/clock_enable_gen_pkg.sv
// Shared constants and types for the clock_enable_gen divider family.
// Default divisors target a 100 MHz system clock.
package clock_enable_gen_pkg;

  localparam int CNT_W_DEF     = 24;
  localparam int PIX_DIV       = 4;        // 100 MHz -> 25 MHz pixel enable
  localparam int PHYS_DIV_60HZ = 1666667;  // 100 MHz -> ~60 Hz frame/physics tick
  localparam int CH_PIX        = 0;
  localparam int CH_PHYS       = 1;

  localparam logic [2*CNT_W_DEF-1:0] DIV_INIT_DEF =
    ((2*CNT_W_DEF)'(PHYS_DIV_60HZ) << (CH_PHYS*CNT_W_DEF)) |
    ((2*CNT_W_DEF)'(PIX_DIV)       << (CH_PIX*CNT_W_DEF));

  // What a channel's counter does on the coming edge.
  typedef enum logic [1:0] {
    ACT_IDLE,
    ACT_CLEAR,
    ACT_WRAP,
    ACT_COUNT
  } cnt_act_t;

endpackage

// File: rtl/clock_enable_gen_div_channel.sv
// One divider channel: wrap counter, active and pending divisor, registered tick
// pulse and square wave. A pending divisor takes effect only at a wrap or while disabled.
module clock_enable_gen_div_channel
  import clock_enable_gen_pkg::*;
#(
  parameter int               CNT_W   = CNT_W_DEF,
  parameter logic [CNT_W-1:0] DIV_RST = CNT_W'(PIX_DIV)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             sync_clear,
  input  logic             cfg_wr,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             pending,
  output logic             tick,
  output logic             div_clk
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] div_act;
  logic [CNT_W-1:0] pend_div;
  logic [CNT_W-1:0] hi_from;
  logic             wrap;
  logic             apply;
  cnt_act_t         act;

  // cnt < div_act always, so cnt_inc cannot overflow.
  always_comb begin
    cnt_inc = cnt + CNT_W'(1);
    hi_from = div_act - (div_act >> 1);
    wrap    = (cnt_inc == div_act);
    apply   = pending && (!en || wrap);
    if (!en)             act = ACT_IDLE;
    else if (sync_clear) act = ACT_CLEAR;
    else if (wrap)       act = ACT_WRAP;
    else                 act = ACT_COUNT;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      div_act <= DIV_RST;
      pending <= 1'b0;
      tick    <= 1'b0;
      div_clk <= 1'b0;
    end else begin
      case (act)
        ACT_WRAP: begin
          cnt     <= '0;
          tick    <= 1'b1;
          div_clk <= 1'b0;
        end
        ACT_COUNT: begin
          cnt     <= cnt_inc;
          tick    <= 1'b0;
          div_clk <= (cnt_inc >= hi_from);
        end
        default: begin
          cnt     <= '0;
          tick    <= 1'b0;
          div_clk <= 1'b0;
        end
      endcase
      // A suppressed wrap (sync_clear) still counts as the apply point.
      if (apply) begin
        div_act <= pend_div;
        pending <= 1'b0;
      end else if (cfg_wr) begin
        pending <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (cfg_wr) pend_div <= cfg_div;
  end

endmodule

// File: rtl/clock_enable_gen.sv
// Multi-channel clock-enable generator: per-channel tick pulses and divided square
// waves, with divisors reprogrammable at runtime through a valid/ready port.
module clock_enable_gen
  import clock_enable_gen_pkg::*;
#(
  parameter  int                        NUM_CH   = 2,
  parameter  int                        CNT_W    = CNT_W_DEF,
  parameter  logic [NUM_CH*CNT_W-1:0]   DIV_INIT = DIV_INIT_DEF,
  localparam int                        CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              CLK100MHZ,
  input  logic              reset,
  input  logic [NUM_CH-1:0] en,
  input  logic              sync_clear,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] div_clk
);

  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] cfg_wr;
  logic [CNT_W-1:0]  div_req;
  logic              pend_sel;

  function automatic logic [CNT_W-1:0] clamp_div(input logic [CNT_W-1:0] d);
    return (d == '0) ? CNT_W'(1) : d;
  endfunction

  // An out-of-range cfg_ch matches no channel: ready, accepted, and dropped.
  always_comb begin
    pend_sel = 1'b0;
    cfg_wr   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_ch == CH_W'(i)) begin
        pend_sel  = pending[i];
        cfg_wr[i] = cfg_valid && !reset && !pending[i];
      end
    end
  end

  assign cfg_ready = !reset && !pend_sel;
  assign div_req   = clamp_div(cfg_div);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clock_enable_gen_div_channel #(
      .CNT_W   (CNT_W),
      .DIV_RST (DIV_INIT[g*CNT_W +: CNT_W])
    ) u_ch (
      .clk        (CLK100MHZ),
      .reset      (reset),
      .en         (en[g]),
      .sync_clear (sync_clear),
      .cfg_wr     (cfg_wr[g]),
      .cfg_div    (div_req),
      .pending    (pending[g]),
      .tick       (tick[g]),
      .div_clk    (div_clk[g])
    );
  end

endmodule

// File: tb/tb_clock_enable_gen.sv
// Directed bench for clock_enable_gen: a period/elapsed-time model checked every cycle,
// plus hand-computed tick and square-wave patterns for each scenario.
module tb_clock_enable_gen;

  localparam int NCH = 3;
  localparam int CW  = 24;
  localparam int CHW = 2;
  localparam logic [NCH*CW-1:0] INIT = {24'd5, 24'd7, 24'd4};

  logic           clk = 1'b0;
  logic           reset;
  logic [NCH-1:0] en;
  logic           sync_clear;
  logic           cfg_valid;
  logic           cfg_ready;
  logic [CHW-1:0] cfg_ch;
  logic [CW-1:0]  cfg_div;
  logic [NCH-1:0] tick;
  logic [NCH-1:0] div_clk;

  int  n_vec = 0;
  int  n_bad = 0;
  bit  chk_on = 1'b0;

  clock_enable_gen #(
    .NUM_CH   (NCH),
    .CNT_W    (CW),
    .DIV_INIT (INIT)
  ) dut (
    .CLK100MHZ  (clk),
    .reset      (reset),
    .en         (en),
    .sync_clear (sync_clear),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_ch     (cfg_ch),
    .cfg_div    (cfg_div),
    .tick       (tick),
    .div_clk    (div_clk)
  );

  always #5 clk = ~clk;

  // Model state: period, edges elapsed since the period phase started, pending request.
  int             m_p[NCH];
  int             m_e[NCH];
  int             m_new[NCH];
  bit             m_pend[NCH];
  logic [NCH-1:0] exp_tick = '0;
  logic [NCH-1:0] exp_dc = '0;

  function automatic bit model_ready(input logic r, input logic [CHW-1:0] ch);
    if (r) return 1'b0;
    if (int'(ch) >= NCH) return 1'b1;
    return !m_pend[ch];
  endfunction

  always @(posedge clk) begin : model
    bit rdy;
    bit wrap;
    bit due;
    rdy = model_ready(reset, cfg_ch);
    for (int c = 0; c < NCH; c++) begin
      due = 1'b0;
      if (reset) begin
        m_p[c]      = int'(INIT[c*CW +: CW]);
        m_e[c]      = 0;
        m_pend[c]   = 1'b0;
        exp_tick[c] = 1'b0;
        exp_dc[c]   = 1'b0;
      end else if (!en[c]) begin
        m_e[c]      = 0;
        exp_tick[c] = 1'b0;
        exp_dc[c]   = 1'b0;
        due         = m_pend[c];
      end else begin
        m_e[c] = m_e[c] + 1;
        wrap   = (m_e[c] % m_p[c]) == 0;
        due    = m_pend[c] && wrap;
        if (sync_clear) begin
          m_e[c]      = 0;
          exp_tick[c] = 1'b0;
          exp_dc[c]   = 1'b0;
        end else begin
          exp_tick[c] = wrap;
          exp_dc[c]   = (m_e[c] % m_p[c]) >= (m_p[c] + 1) / 2;
        end
      end
      if (due) begin
        m_p[c]    = m_new[c];
        m_pend[c] = 1'b0;
        m_e[c]    = 0;
      end
      if (cfg_valid && rdy && int'(cfg_ch) == c) begin
        m_new[c]  = (cfg_div == '0) ? 1 : int'(cfg_div);
        m_pend[c] = 1'b1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, want %0h", name, $time, act, exp);
    end
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      if (chk_on) begin
        check("cyc_tick", 32'(tick), 32'(exp_tick));
        check("cyc_div_clk", 32'(div_clk), 32'(exp_dc));
        check("cyc_cfg_ready", 32'(cfg_ready), 32'(model_ready(reset, cfg_ch)));
      end
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic cfg_write(input int ch, input int div);
    int k;
    cfg_ch    = CHW'(ch);
    cfg_div   = CW'(div);
    cfg_valid = 1'b1;
    #1;
    k = 0;
    while (!cfg_ready && k < 40) begin
      step(1);
      #1;
      k++;
    end
    check("cfg_accept_ready", 32'(cfg_ready), 32'd1);
    step(1);
    cfg_valid = 1'b0;
  endtask

  task automatic wait_tick(input int c, input int budget);
    int k;
    k = 0;
    do begin
      step(1);
      k++;
    end while (!tick[c] && k < budget);
    check("wait_tick", 32'(tick[c]), 32'd1);
  endtask

  task automatic record(input int n, output logic [NCH-1:0][31:0] tp, output logic [31:0] dp0);
    tp  = '0;
    dp0 = '0;
    for (int k = 0; k < n; k++) begin
      step(1);
      for (int c = 0; c < NCH; c++) tp[c][k] = tick[c];
      dp0[k] = div_clk[0];
    end
  endtask

  logic [NCH-1:0][31:0] tp;
  logic [31:0]          dp;

  initial begin
    reset      = 1'b1;
    en         = '0;
    sync_clear = 1'b0;
    cfg_valid  = 1'b0;
    cfg_ch     = '0;
    cfg_div    = '0;
    fork
      compare_loop();
    join_none

    // Reset and default divisors
    step(1);
    chk_on = 1'b1;
    step(1);
    check("rst_tick", 32'(tick), 32'd0);
    check("rst_div_clk", 32'(div_clk), 32'd0);
    #1;
    check("rst_cfg_ready", 32'(cfg_ready), 32'd0);
    reset = 1'b0;
    en    = 3'b111;
    record(20, tp, dp);
    check("t1_tick0_pattern", 32'(tp[0][19:0]), 32'h88888);
    check("t1_tick0_count", 32'($countones(tp[0])), 32'd5);
    check("t1_divclk0_period", 32'(dp[3:0]), 32'b0110);

    // Mid-period reprogram of ch0 to 10
    step(1);
    cfg_write(0, 10);
    #1;
    check("t2_ready_low", 32'(cfg_ready), 32'd0);
    step(1);
    check("t2_no_tick_yet", 32'(tick[0]), 32'd0);
    step(1);
    check("t2_old_period_tick", 32'(tick[0]), 32'd1);
    #1;
    check("t2_ready_back", 32'(cfg_ready), 32'd1);
    record(10, tp, dp);
    check("t2_tick0_spacing", 32'(tp[0][9:0]), 32'b1000000000);
    check("t2_divclk0_5lo5hi", 32'(dp[9:0]), 32'b0111110000);

    // Divisor 0 is treated as 1, then divisor 5
    cfg_write(0, 0);
    wait_tick(0, 20);
    record(5, tp, dp);
    check("t3_div1_tick", 32'(tp[0][4:0]), 32'b11111);
    check("t3_div1_divclk", 32'(dp[4:0]), 32'd0);
    cfg_write(0, 5);
    record(6, tp, dp);
    check("t3_div5_tick", 32'(tp[0][5:0]), 32'b100001);
    check("t3_div5_divclk", 32'(dp[5:0]), 32'b011000);

    // sync_clear on the ch0 terminal-count edge
    cfg_write(0, 4);
    cfg_write(1, 6);
    step(20);
    wait_tick(0, 10);
    step(3);
    sync_clear = 1'b1;
    step(1);
    sync_clear = 1'b0;
    check("t4_clear_tick", 32'(tick), 32'd0);
    check("t4_clear_divclk", 32'(div_clk), 32'd0);
    record(6, tp, dp);
    check("t4_tick0_after_clear", 32'(tp[0][5:0]), 32'b001000);
    check("t4_tick1_after_clear", 32'(tp[1][5:0]), 32'b100000);
    check("t4_tick2_after_clear", 32'(tp[2][5:0]), 32'b010000);

    // Reset with a ch1 update pending
    cfg_write(1, 3);
    reset = 1'b1;
    #1;
    check("t5_ready_in_reset", 32'(cfg_ready), 32'd0);
    step(1);
    check("t5_reset_tick", 32'(tick), 32'd0);
    check("t5_reset_divclk", 32'(div_clk), 32'd0);
    reset = 1'b0;
    #1;
    check("t5_ready_after", 32'(cfg_ready), 32'd1);
    record(7, tp, dp);
    check("t5_tick1_init_div", 32'(tp[1][6:0]), 32'b1000000);
    check("t5_tick0_init_div", 32'(tp[0][6:0]), 32'b0001000);

    // Disabled channel applies its pending divisor immediately
    cfg_write(0, 3);
    en = 3'b110;
    #1;
    check("t6_ready_pending", 32'(cfg_ready), 32'd0);
    step(1);
    check("t6_dis_tick", 32'(tick[0]), 32'd0);
    check("t6_dis_divclk", 32'(div_clk[0]), 32'd0);
    #1;
    check("t6_ready_applied", 32'(cfg_ready), 32'd1);
    en = 3'b111;
    record(3, tp, dp);
    check("t6_first_tick", 32'(tp[0][2:0]), 32'b100);

    // Out-of-range channel select
    cfg_ch    = 2'd3;
    cfg_div   = 24'd2;
    cfg_valid = 1'b1;
    #1;
    check("t6_oor_ready", 32'(cfg_ready), 32'd1);
    step(1);
    cfg_valid = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      cfg_ch = CHW'(i);
      #1;
      check("t6_oor_no_pending", 32'(cfg_ready), 32'd1);
      step(1);
    end
    step(12);

    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
